// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage_pkg
// Brief   : ALUInstr opcode enum, RV32I OP/OP-IMM decode constants and helper.
// Revision: 1.0 - initial release
// ============================================================================
package alu_issue_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLL = 4'd2,
        ALU_SLT = 4'd3,
        ALU_ULT = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_OR  = 4'd8,
        ALU_AND = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // alt selects SUB/SRA on the funct3 codes that have an alternate form
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_ULT;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : issue_scoreboard
// Brief   : Per-register pending-write bits; a same-cycle set beats a clear.
// Revision: 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_idx_i,
    input  logic [4:0] rs1_idx_i,
    input  logic [4:0] rs2_idx_i,
    output logic       rs1_busy_o,
    output logic       rs2_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // A writeback landing this cycle already frees the register for issue
    assign rs1_busy_o = busy_q[rs1_idx_i] && !(clr_en_i && (clr_idx_i == rs1_idx_i));
    assign rs2_busy_o = busy_q[rs2_idx_i] && !(clr_en_i && (clr_idx_i == rs2_idx_i));

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage
// Brief   : RV32I OP/OP-IMM decode, regfile read with writeback bypass,
//           scoreboard hazard stall and one-entry valid/ready ALU output stage.
//           ALU_ISSUE_PERF_EN enables the issue/stall performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_i,
    output logic             instr_ready_o,
    output logic             alu_valid_o,
    input  logic             alu_ready_i,
    output logic [31:0]      alu_in1_o,
    output logic [31:0]      alu_in2_o,
    output logic [3:0]       alu_opcode_o,
    output logic [4:0]       alu_rd_o,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [31:0]      wb_data_i,
    output logic             illegal_o,
    output logic [CNT_W-1:0] issue_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_is_op, w_legal;
    alu_op_e     w_op;
    logic [31:0] w_imm, w_rs1_val, w_rs2_val;
    logic        w_rs1_busy, w_rs2_busy, w_hazard, w_accept, w_issue, w_wb_we;

    logic [31:0] regs_q [NREGS];
    logic        alu_valid_q, alu_valid_d;
    logic [31:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    alu_op_e     alu_op_q, alu_op_d;
    logic [4:0]  alu_rd_q, alu_rd_d;
    logic        illegal_q, illegal_d;

    assign w_opc = instr_i[6:0];
    assign w_rd  = instr_i[11:7];
    assign w_f3  = instr_i[14:12];
    assign w_rs1 = instr_i[19:15];
    assign w_rs2 = instr_i[24:20];
    assign w_f7  = instr_i[31:25];

    always_comb begin
        w_is_op = 1'b0;
        w_legal = 1'b0;
        w_op    = ALU_ADD;
        w_imm   = {{20{instr_i[31]}}, instr_i[31:20]};
        case (w_opc)
            OPC_OP: begin
                w_is_op = 1'b1;
                w_legal = (w_f7 == F7_ZERO) ||
                          ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)));
                w_op    = f3_to_op(w_f3, w_f7 == F7_ALT);
            end
            OPC_OP_IMM: begin
                w_op = f3_to_op(w_f3, (w_f3 == F3_SRL_SRA) && (w_f7 == F7_ALT));
                case (w_f3)
                    F3_SLL: begin
                        w_legal = (w_f7 == F7_ZERO);
                        w_imm   = {27'b0, w_rs2};
                    end
                    F3_SRL_SRA: begin
                        w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
                        w_imm   = {27'b0, w_rs2};
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign w_wb_we   = wb_valid_i && (wb_rd_i != 5'd0);
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                       (wb_valid_i && (wb_rd_i == w_rs1)) ? wb_data_i : regs_q[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                       (wb_valid_i && (wb_rd_i == w_rs2)) ? wb_data_i : regs_q[w_rs2];

    // Illegal instructions never stall on the scoreboard; they only need the slot
    assign w_hazard      = w_legal && (w_rs1_busy || (w_is_op && w_rs2_busy));
    assign instr_ready_o = (!alu_valid_q || alu_ready_i) && !w_hazard;
    assign w_accept      = instr_valid_i && instr_ready_o;
    assign w_issue       = w_accept && w_legal;

    issue_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (w_issue && (w_rd != 5'd0)),
        .set_idx_i  (w_rd),
        .clr_en_i   (w_wb_we),
        .clr_idx_i  (wb_rd_i),
        .rs1_idx_i  (w_rs1),
        .rs2_idx_i  (w_rs2),
        .rs1_busy_o (w_rs1_busy),
        .rs2_busy_o (w_rs2_busy)
    );

    always_comb begin
        alu_valid_d = alu_valid_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_op_d    = alu_op_q;
        alu_rd_d    = alu_rd_q;
        illegal_d   = w_accept && !w_legal;
        if (w_issue) begin
            alu_valid_d = 1'b1;
            alu_in1_d   = w_rs1_val;
            alu_in2_d   = w_is_op ? w_rs2_val : w_imm;
            alu_op_d    = w_op;
            alu_rd_d    = w_rd;
        end else if (alu_ready_i) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_q <= 1'b0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= ALU_ADD;
            alu_rd_q    <= '0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            alu_valid_q <= alu_valid_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_op_q    <= alu_op_d;
            alu_rd_q    <= alu_rd_d;
            illegal_q   <= illegal_d;
            if (w_wb_we) regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    assign alu_valid_o  = alu_valid_q;
    assign alu_in1_o    = alu_in1_q;
    assign alu_in2_o    = alu_in2_q;
    assign alu_opcode_o = alu_op_q;
    assign alu_rd_o     = alu_rd_q;
    assign illegal_o    = illegal_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (w_issue)                         issue_cnt_q <= issue_cnt_q + 1'b1;
            if (instr_valid_i && !instr_ready_o) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign issue_cnt_o = issue_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign issue_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_stage
// Brief   : Directed scenarios plus random traffic against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_ready, alu_valid, alu_ready;
    logic [31:0] instr, alu_in1, alu_in2, wb_data;
    logic [3:0]  alu_opcode;
    logic [4:0]  alu_rd, wb_rd;
    logic        wb_valid, illegal;
    logic [31:0] issue_cnt, stall_cnt;

    alu_issue_stage #(.NREGS(32), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_ready_o (instr_ready),
        .alu_valid_o   (alu_valid),
        .alu_ready_i   (alu_ready),
        .alu_in1_o     (alu_in1),
        .alu_in2_o     (alu_in2),
        .alu_opcode_o  (alu_opcode),
        .alu_rd_o      (alu_rd),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .illegal_o     (illegal),
        .issue_cnt_o   (issue_cnt),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    // reference state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_v, m_ill;
    logic [31:0] m_in1, m_in2, m_icnt, m_scnt;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    bit          last_ready;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {imm, 5'(rs1), f3, 5'(rd), 7'h13};
    endfunction

    // Mnemonic-level decode: legal flag, whether rs2 is a register source, opcode, operand 2 imm
    task automatic ref_decode(input logic [31:0] ins, output bit legal, output bit is_r,
                              output logic [3:0] op, output logic [31:0] imm);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        legal = 0; is_r = 0; op = 4'd0;
        imm = {{20{ins[31]}}, ins[31:20]};
        if (ins[6:0] == 7'h33) begin
            is_r = 1;
            if (f7 == 7'h00) begin
                legal = 1;
                case (f3)
                    3'd0: op = ALU_ADD;  3'd1: op = ALU_SLL;  3'd2: op = ALU_SLT;
                    3'd3: op = ALU_ULT;  3'd4: op = ALU_XOR;  3'd5: op = ALU_SRL;
                    3'd6: op = ALU_OR;   default: op = ALU_AND;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                legal = 1; op = ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                legal = 1; op = ALU_SRA;
            end
        end else if (ins[6:0] == 7'h13) begin
            case (f3)
                3'd0: begin legal = 1; op = ALU_ADD; end
                3'd2: begin legal = 1; op = ALU_SLT; end
                3'd3: begin legal = 1; op = ALU_ULT; end
                3'd4: begin legal = 1; op = ALU_XOR; end
                3'd6: begin legal = 1; op = ALU_OR;  end
                3'd7: begin legal = 1; op = ALU_AND; end
                3'd1: begin
                    imm = 32'(ins[24:20]);
                    if (f7 == 7'h00) begin legal = 1; op = ALU_SLL; end
                end
                default: begin
                    imm = 32'(ins[24:20]);
                    if (f7 == 7'h00) begin legal = 1; op = ALU_SRL; end
                    else if (f7 == 7'h20) begin legal = 1; op = ALU_SRA; end
                end
            endcase
        end
    endtask

    function automatic logic [31:0] rd_val(input int r);
        if (r == 0) return 32'd0;
        if (wb_valid && int'(wb_rd) == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit busy_now(input int r);
        return m_busy[r] && !(wb_valid && int'(wb_rd) == r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
        m_v = 0; m_ill = 0; m_in1 = 0; m_in2 = 0; m_op = 0; m_rd = 0; m_icnt = 0; m_scnt = 0;
    endtask

    // One cycle: drive at negedge, check ready, advance model, check registered outputs
    task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit ar,
                        input bit wv, input logic [4:0] wr, input logic [31:0] wd);
        bit legal, is_r, exp_ready, acc;
        logic [3:0]  op;
        logic [31:0] imm;
        int rs1, rs2, rd;
        @(negedge clk);
        rst = r; instr_valid = iv; instr = ins; alu_ready = ar;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        #1;
        ref_decode(ins, legal, is_r, op, imm);
        rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]); rd = int'(ins[11:7]);
        exp_ready = (!m_v || ar) && !(legal && (busy_now(rs1) || (is_r && busy_now(rs2))));
        last_ready = instr_ready;
        check("instr_ready", {31'd0, instr_ready}, {31'd0, exp_ready});
        acc = iv && exp_ready;
        if (r) begin
            model_reset();
        end else begin
            if (iv && !exp_ready) m_scnt++;
            m_ill = acc && !legal;
            if (acc && legal) begin
                m_v = 1; m_in1 = rd_val(rs1); m_in2 = is_r ? rd_val(rs2) : imm;
                m_op = op; m_rd = 5'(rd); m_icnt++;
            end else if (ar) begin
                m_v = 0;
            end
            if (wv && wr != 0) begin m_regs[wr] = wd; m_busy[wr] = 0; end
            if (acc && legal && rd != 0) m_busy[rd] = 1;
        end
        @(posedge clk);
        #1;
        check("alu_valid", {31'd0, alu_valid}, {31'd0, m_v});
        check("alu_in1", alu_in1, m_in1);
        check("alu_in2", alu_in2, m_in2);
        check("alu_opcode", {28'd0, alu_opcode}, {28'd0, m_op});
        check("alu_rd", {27'd0, alu_rd}, {27'd0, m_rd});
        check("illegal", {31'd0, illegal}, {31'd0, m_ill});
`ifdef ALU_ISSUE_PERF_EN
        check("issue_cnt", issue_cnt, m_icnt);
        check("stall_cnt", stall_cnt, m_scnt);
`else
        check("issue_cnt", issue_cnt, 32'd0);
        check("stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        logic [6:0] f7;
        k = $urandom_range(0, 9);
        f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00);
        if (k < 4) return enc_r(f7, $urandom_range(0, 7), $urandom_range(0, 7), 3'($urandom), $urandom_range(0, 7));
        if (k < 7) return enc_i(12'($urandom), $urandom_range(0, 7), 3'($urandom), $urandom_range(0, 7));
        if (k < 9) return enc_i({f7, 5'($urandom)}, $urandom_range(0, 7),
                                ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5, $urandom_range(0, 7));
        return $urandom;
    endfunction

    initial begin
        rst = 1; instr_valid = 0; instr = 0; alu_ready = 1; wb_valid = 0; wb_rd = 0; wb_data = 0;
        model_reset();
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        check("rst_valid", {31'd0, alu_valid}, 32'd0);

        // ADDI x1,x0,5
        step(0, 1, 32'h00500093, 1, 0, 0, 0);
        check("t1_valid", {31'd0, alu_valid}, 32'd1);
        check("t1_in2", alu_in2, 32'd5);
        check("t1_op", {28'd0, alu_opcode}, {28'd0, ALU_ADD});
        // SUB x3,x1,x2 stalls on x1, then issues with the bypassed writeback
        step(0, 1, enc_r(7'h20, 2, 1, 3'd0, 3), 1, 0, 0, 0);
        check("t2_stall", {31'd0, last_ready}, 32'd0);
        step(0, 1, enc_r(7'h20, 2, 1, 3'd0, 3), 1, 1, 5'd1, 32'd7);
        check("t2_ready", {31'd0, last_ready}, 32'd1);
        check("t2_in1", alu_in1, 32'd7);
        check("t2_op", {28'd0, alu_opcode}, {28'd0, ALU_SUB});
        // back-pressure hold then back-to-back issue of ADD x5,x0,x0
        for (int i = 0; i < 3; i++) begin
            step(0, 1, enc_r(7'h00, 0, 0, 3'd0, 5), 0, 0, 0, 0);
            check("t3_hold_in1", alu_in1, 32'd7);
        end
        step(0, 1, enc_r(7'h00, 0, 0, 3'd0, 5), 1, 0, 0, 0);
        check("t3_rd", {27'd0, alu_rd}, 32'd5);
        // SRAI x2,x1,4 then SLLI with funct7=0x20
        step(0, 1, 32'h4040D113, 1, 0, 0, 0);
        check("t4_op", {28'd0, alu_opcode}, {28'd0, ALU_SRA});
        check("t4_in2", alu_in2, 32'd4);
        step(0, 1, enc_i({7'h20, 5'd3}, 1, 3'd1, 6), 1, 0, 0, 0);
        check("t4_illegal", {31'd0, illegal}, 32'd1);
        check("t4_valid", {31'd0, alu_valid}, 32'd0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t4_pulse", {31'd0, illegal}, 32'd0);
        // x0 writes ignored, x0 never busy
        step(0, 0, 0, 1, 1, 5'd0, 32'hFFFF_FFFF);
        step(0, 1, enc_r(7'h00, 0, 0, 3'd0, 4), 1, 0, 0, 0);
        check("t5_in1", alu_in1, 32'd0);
        check("t5_in2", alu_in2, 32'd0);
        step(0, 1, enc_i(12'd1, 0, 3'd0, 0), 1, 0, 0, 0);
        step(0, 1, enc_r(7'h00, 0, 0, 3'd0, 6), 1, 0, 0, 0);
        check("t5_x0_free", {31'd0, last_ready}, 32'd1);
        // reset drops a held operation and clears registers and scoreboard
        step(0, 1, enc_i(12'd9, 0, 3'd0, 3), 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t6_valid", {31'd0, alu_valid}, 32'd0);
        step(0, 1, enc_r(7'h00, 3, 1, 3'd0, 7), 1, 0, 0, 0);
        check("t6_ready", {31'd0, last_ready}, 32'd1);
        check("t6_in1", alu_in1, 32'd0);

        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
